data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning stall cycles per access (legal range 1..15).
REQ-002 SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of two).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port MemRead_i  input  1  load request, driven from the EX/MEM register.
REQ-006 SHALL have port MemWrite_i  input  1  store request, driven from the EX/MEM register.
REQ-007 SHALL have port addr_i  input  32  byte address (ALU result).
REQ-008 SHALL have port data_i  input  32  store data.
REQ-009 SHALL have port data_o  output  32  registered load data, to MEM/WB.
REQ-010 SHALL have port stall_o  output  1  pipeline freeze request to PC, IF/ID, ID/EX, EX/MEM.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse flagging a rejected request.
REQ-012 SHALL have port acc_cnt_o  output  16  count of completed accesses.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE with a 4-bit down-counter cnt.
REQ-014 SHALL define request req = MemRead_i XOR MemWrite_i, and bad = (MemRead_i AND MemWrite_i) OR (addr_i[1:0] != 0 AND (MemRead_i OR MemWrite_i)) OR (addr_i >= DEPTH*4 AND (MemRead_i OR MemWrite_i)).
REQ-015 SHALL, in IDLE with req and not bad: go to BUSY with cnt = LATENCY-2 when LATENCY>1, else go directly to DONE.
REQ-016 SHALL, in BUSY: decrement cnt; when cnt==0, go to DONE on the next edge.
REQ-017 SHALL, in DONE: go to IDLE unconditionally and ignore the held request, so one instruction never triggers two accesses.
REQ-018 SHALL drive stall_o combinationally = (IDLE AND req AND NOT bad) OR BUSY, so stall_o is high for exactly LATENCY consecutive cycles per access and low in DONE.
REQ-019 SHALL latch addr_i, data_i and the operation type on the IDLE->BUSY/DONE edge, and use only the latched values for the access.
REQ-020 SHALL commit stores to mem[addr[log2(DEPTH)+1:2]] on the edge entering DONE.
REQ-021 SHALL load data_o from memory on the edge entering DONE, and hold it until the next completed load; stores SHALL NOT change data_o.
REQ-022 SHALL, in IDLE with bad: raise err_o for one cycle, stay in IDLE, perform no access, keep stall_o low.
REQ-023 SHALL increment acc_cnt_o on each edge entering DONE, saturating at 16'hFFFF.
REQ-024 SHALL ignore MemRead_i/MemWrite_i changes while in BUSY or DONE.

Reset
REQ-025 SHALL, while rst_i is low, force state=IDLE, cnt=0, data_o=0, stall_o=0, err_o=0, acc_cnt_o=0, independent of clk_i.
REQ-026 SHALL abort an in-flight access when reset asserts mid-operation; an aborted store SHALL NOT modify memory.
REQ-027 SHALL NOT reset memory array contents.

Verification
REQ-028 SHALL verify a store then a load: LATENCY=4, store 0xDEADBEEF to addr 0x10, then load 0x10 -> stall_o high 4 cycles for each access; after the load's DONE edge, data_o=0xDEADBEEF and acc_cnt_o=2.
REQ-029 SHALL verify LATENCY=1: load from addr 0x0 (preloaded 0x12345678) -> stall_o high exactly 1 cycle, DONE next, data_o=0x12345678.
REQ-030 SHALL verify rejected requests: load addr 0x13, then store addr 0x400 with DEPTH=256, then MemRead_i=MemWrite_i=1 -> each gives a one-cycle err_o, stall_o stays 0, acc_cnt_o is unchanged, memory is unchanged.
REQ-031 SHALL verify reset mid-store: store 0xA5A5A5A5 to 0x20, pull rst_i low in the 2nd BUSY cycle -> outputs zero immediately, and a later load of 0x20 returns the old value.
REQ-032 SHALL verify a held request: MemRead_i stays high through DONE and one extra cycle -> exactly one access, acc_cnt_o increments by 1, and the next IDLE cycle starts a new access only if the request is still present.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory controller: freezes the pipeline for LATENCY cycles per
// load/store, rejects malformed requests with a one-cycle error pulse.
module data_mem_ctrl #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stall_o,
   output logic        err_o,
   output logic [15:0] acc_cnt_o
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [3:0]      r_cnt, w_cnt_nxt;
   logic [AW-1:0]   r_idx;
   logic [31:0]     r_wdata;
   logic            r_wr;
   logic [31:0]     r_dout;
   logic            r_err;
   logic [15:0]     r_acc;
   logic [31:0]     mem [DEPTH];

   logic            w_any, w_req, w_bad, w_start, w_enter_done, w_wr;
   logic [AW-1:0]   w_idx;
   logic [31:0]     w_wdata;

   // Request decode: exactly one op, word aligned, inside the array
   assign w_any   = MemRead_i | MemWrite_i;
   assign w_req   = MemRead_i ^ MemWrite_i;
   assign w_bad   = (MemRead_i & MemWrite_i)
                  | (w_any & (addr_i[1:0] != 2'b00))
                  | (w_any & (|addr_i[31:AW+2]));
   assign w_start = (r_state == IDLE) & w_req & ~w_bad;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               if (LATENCY > 1) begin
                  w_state_nxt = BUSY;
                  w_cnt_nxt   = CNT_INIT;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         BUSY: begin
            if (r_cnt == 4'd0) w_state_nxt = DONE;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // With LATENCY==1 the access completes on the latching edge, so use the live inputs then
   assign w_wr         = (r_state == IDLE) ? MemWrite_i       : r_wr;
   assign w_idx        = (r_state == IDLE) ? addr_i[AW+1:2]   : r_idx;
   assign w_wdata      = (r_state == IDLE) ? data_i           : r_wdata;
   assign w_enter_done = rst_i & (w_state_nxt == DONE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_wr    <= 1'b0;
         r_dout  <= 32'd0;
         r_err   <= 1'b0;
         r_acc   <= 16'd0;
      end else begin
         r_err <= (r_state == IDLE) & w_bad;
         if (w_start) begin
            r_idx   <= addr_i[AW+1:2];
            r_wdata <= data_i;
            r_wr    <= MemWrite_i;
         end
         if (w_enter_done) begin
            if (!w_wr) r_dout <= mem[w_idx];
            if (r_acc != 16'hFFFF) r_acc <= r_acc + 16'd1;
         end
      end
   end

   // Array is deliberately unreset; reset gating on w_enter_done drops aborted stores
   always_ff @(posedge clk_i) begin
      if (w_enter_done && w_wr) mem[w_idx] <= w_wdata;
   end

   assign stall_o   = rst_i & (w_start | (r_state == BUSY));
   assign data_o    = r_dout;
   assign err_o     = r_err;
   assign acc_cnt_o = r_acc;

endmodule
